// File: rtl/io_out_buf_pkg.sv
// Shared width helpers for the output-port buffer slice.
// Entries are packed as {addr[AW-1:0], data[NUBITS-1:0]}, so EW = AW + NUBITS.
package io_out_buf_pkg;

  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_cw(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int calc_ew(input int aw, input int nubits);
    return aw + nubits;
  endfunction

endpackage

// File: rtl/io_out_buf_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with occupancy count; storage is never cleared.
module fifo_sync
  import io_out_buf_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int D  = 4,
  localparam int CW = calc_cw(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(D));
  assign empty = (count == '0);

endmodule

// File: rtl/io_out_buf.sv
// Output-port stage: per-port last-value bank, update pulses, and a FIFO of {addr,data}
// writes drained by valid/ready; a write arriving while full is dropped and flagged in ovf.
module io_out_buf
  import io_out_buf_pkg::*;
#(
  parameter  int NUBITS = 32,
  parameter  int NUIOOU = 8,
  parameter  int FDEPTH = 4,
  localparam int AW     = calc_aw(NUIOOU),
  localparam int CW     = calc_cw(FDEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     out_en,
  input  logic [AW-1:0]            addr_out,
  input  logic [NUBITS-1:0]        data_out,
  output logic [NUIOOU*NUBITS-1:0] port_reg,
  output logic [NUIOOU-1:0]        port_upd,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [AW-1:0]            q_addr,
  output logic [NUBITS-1:0]        q_data,
  output logic [CW-1:0]            q_count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int EW = calc_ew(AW, NUBITS);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     head;
  logic [NUIOOU-1:0] port_sel;

  // Out-of-range addresses select no port but are still queued.
  always_comb begin
    port_sel = '0;
    for (int unsigned p = 0; p < NUIOOU; p++) begin
      port_sel[p] = out_en && ((NUIOOU == 1) || (32'(addr_out) == 32'(p)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_reg <= '0;
      port_upd <= '0;
    end else begin
      port_upd <= port_sel;
      for (int unsigned p = 0; p < NUIOOU; p++) begin
        if (port_sel[p]) port_reg[p*NUBITS +: NUBITS] <= data_out;
      end
    end
  end

  assign pop     = q_valid && q_ready;
  assign push    = out_en && (!full || pop);
  assign q_valid = !empty;

  always_ff @(posedge clk) begin
    if (rst)                         ovf <= 1'b0;
    else if (out_en && full && !pop) ovf <= 1'b1;
    else if (ovf_clr)                ovf <= 1'b0;
  end

  fifo_sync #(
    .W (EW),
    .D (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_out, data_out}),
    .rdata (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  assign {q_addr, q_data} = head;

endmodule

// File: tb/tb_io_out_buf.sv
// Directed and random bench for io_out_buf against a queue-based reference model.
module tb_io_out_buf;

  localparam int NUBITS = 32;
  localparam int NUIOOU = 8;
  localparam int FDEPTH = 4;
  localparam int AW     = 3;
  localparam int CW     = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     out_en = 1'b0;
  logic [AW-1:0]            addr_out = '0;
  logic [NUBITS-1:0]        data_out = '0;
  logic [NUIOOU*NUBITS-1:0] port_reg;
  logic [NUIOOU-1:0]        port_upd;
  logic                     q_valid;
  logic                     q_ready = 1'b0;
  logic [AW-1:0]            q_addr;
  logic [NUBITS-1:0]        q_data;
  logic [CW-1:0]            q_count;
  logic                     ovf;
  logic                     ovf_clr = 1'b0;

  io_out_buf #(
    .NUBITS (NUBITS),
    .NUIOOU (NUIOOU),
    .FDEPTH (FDEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .out_en   (out_en),
    .addr_out (addr_out),
    .data_out (data_out),
    .port_reg (port_reg),
    .port_upd (port_upd),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_addr   (q_addr),
    .q_data   (q_data),
    .q_count  (q_count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [AW+NUBITS-1:0] mq[$];
  logic [NUBITS-1:0]    m_ports [NUIOOU];
  logic [NUIOOU-1:0]    m_upd;
  logic                 m_ovf;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int p = 0; p < NUIOOU; p++) m_ports[p] = '0;
    m_upd = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                            input logic rdy, input logic clr);
    bit do_pop, do_push, is_full;
    is_full = (mq.size() == FDEPTH);
    do_pop  = (mq.size() != 0) && rdy;
    do_push = en && (!is_full || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({a, d});
    m_upd = '0;
    if (en && int'(a) < NUIOOU) begin
      m_ports[a] = d;
      m_upd[a]   = 1'b1;
    end
    if (en && is_full && !do_pop) m_ovf = 1'b1;
    else if (clr)                 m_ovf = 1'b0;
  endtask

  task automatic check_all();
    check("q_valid", 64'(q_valid), 64'(mq.size() != 0));
    check("q_count", 64'(q_count), 64'(mq.size()));
    check("ovf", 64'(ovf), 64'(m_ovf));
    check("port_upd", 64'(port_upd), 64'(m_upd));
    if (mq.size() != 0) begin
      check("q_addr", 64'(q_addr), 64'(mq[0][AW+NUBITS-1:NUBITS]));
      check("q_data", 64'(q_data), 64'(mq[0][NUBITS-1:0]));
    end
    for (int p = 0; p < NUIOOU; p++)
      check($sformatf("port_reg[%0d]", p), 64'(port_reg[p*NUBITS +: NUBITS]), 64'(m_ports[p]));
  endtask

  task automatic step(input logic en, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                      input logic rdy, input logic clr);
    out_en = en; addr_out = a; data_out = d; q_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_step(en, a, d, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic en, input logic rdy, input logic clr);
    rst = 1'b1; out_en = en; addr_out = 3'd5; data_out = 32'h1234_5678; q_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;

    // 1: reset then idle
    do_reset(1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("t1_qvalid", 64'(q_valid), 64'd0);

    // 2: single write then pop
    step(1'b1, 3'd3, 32'h0000_00A5, 1'b0, 1'b0);
    check("t2_upd", 64'(port_upd), 64'h08);
    check("t2_qdata", 64'(q_data), 64'hA5);
    check("t2_qaddr", 64'(q_addr), 64'd3);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t2_empty", 64'(q_count), 64'd0);

    // 3: overflow by five back-to-back writes, drain, clear
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 32'(10 + i), 1'b0, 1'b0);
    check("t3_cnt", 64'(q_count), 64'd4);
    check("t3_ovf", 64'(ovf), 64'd1);
    check("t3_port4", 64'(port_reg[4*NUBITS +: NUBITS]), 64'd14);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 64'(q_data), 64'(10 + i));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("t3_ovfclr", 64'(ovf), 64'd0);

    // 4: full with simultaneous pop and write
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("t4_cnt", 64'(q_count), 64'd4);
    check("t4_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("t4_last_data", 64'(q_data), 64'hFFFF_FFFF);
    check("t4_last_addr", 64'(q_addr), 64'd7);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // 5: streaming with wraparound
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'(i), 32'(100 + i), 1'b1, 1'b0);
      check("t5_cnt_le1", 64'(q_count <= 1), 64'd1);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // 6: reset with entries queued and activity on the inputs
    step(1'b1, 3'd1, 32'hAAAA_0001, 1'b0, 1'b0);
    step(1'b1, 3'd2, 32'hAAAA_0002, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1, 1'b1);
    check("t6_cnt", 64'(q_count), 64'd0);
    step(1'b1, 3'd6, 32'hBEEF_0006, 1'b0, 1'b0);
    check("t6_head", 64'(q_data), 64'hBEEF_0006);
    check("t6_cnt1", 64'(q_count), 64'd1);

    // random traffic including ovf_clr coinciding with overflow
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end
    do_reset(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
